// File: rtl/hazard_pkg.sv
// Shared types and defaults for the ID-stage hazard scoreboard and the pipeline top.
// Entry addresses are held at MAX_ADDR_W bits so one struct serves every ADDR_W up to that width.
package hazard_pkg;

  localparam int NUM_REGS_DEF   = 32;
  localparam int ADDR_W_DEF     = 5;
  localparam int DEPTH_DEF      = 3;
  localparam int LOAD_READY_DEF = 2;
  localparam int CNT_W_DEF      = 16;

  // Widest register address an entry can hold; narrower addresses are zero-extended.
  localparam int MAX_ADDR_W = 8;

  // Forward select value meaning "read the register file".
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic                  valid;
    logic [MAX_ADDR_W-1:0] rd;
    logic                  is_load;
  } entry_t;

  function automatic logic [MAX_ADDR_W-1:0] widen_addr(input logic [MAX_ADDR_W-1:0] addr);
    return addr;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Priority search of the tracked stages for one source register.
// Reports the youngest producing stage (lowest k) and whether that producer is a load.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int SEL_W  = $clog2(DEPTH_DEF + 1)
) (
  input  entry_t [DEPTH:1]    entries,
  input  logic   [ADDR_W-1:0] src,
  input  logic                used,
  output logic   [SEL_W-1:0]  sel,
  output logic                is_load_hit
);

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves it unassigned,
    // which would otherwise infer a latch.
    sel         = SEL_W'(FWD_RF);
    is_load_hit = 1'b0;
    if (used && (src != '0)) begin
      // Walk from the oldest stage to the youngest so the youngest hit overwrites older ones.
      for (int k = DEPTH; k >= 1; k--) begin
        if (entries[k].valid && (entries[k].rd == widen_addr(MAX_ADDR_W'(src)))) begin
          sel         = SEL_W'(k);
          is_load_hit = entries[k].is_load;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard beside ID: tracks in-flight register writes per downstream stage,
// drives forwarding selects, the ID stall, a per-register pending vector and a stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter  int NUM_REGS   = NUM_REGS_DEF,
  parameter  int ADDR_W     = ADDR_W_DEF,
  parameter  int DEPTH      = DEPTH_DEF,
  parameter  int LOAD_READY = LOAD_READY_DEF,
  parameter  int CNT_W      = CNT_W_DEF,
  localparam int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [ADDR_W-1:0]   id_rs,
  input  logic [ADDR_W-1:0]   id_rt,
  input  logic                id_rs_used,
  input  logic                id_rt_used,
  input  logic [ADDR_W-1:0]   id_rd,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                flush,
  input  logic                ext_hold,
  output logic                stall,
  output logic [SEL_W-1:0]    fwd_rs_sel,
  output logic [SEL_W-1:0]    fwd_rt_sel,
  output logic [NUM_REGS-1:0] pending,
  output logic [CNT_W-1:0]    stall_cycles
);

  entry_t [DEPTH:1] entries;
  entry_t           issue;

  logic [SEL_W-1:0] rs_sel;
  logic [SEL_W-1:0] rt_sel;
  logic             rs_load_hit;
  logic             rt_load_hit;
  logic             rs_hazard;
  logic             rt_hazard;

  hazard_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .SEL_W  (SEL_W)
  ) u_match_rs (
    .entries     (entries),
    .src         (id_rs),
    .used        (id_rs_used),
    .sel         (rs_sel),
    .is_load_hit (rs_load_hit)
  );

  hazard_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .SEL_W  (SEL_W)
  ) u_match_rt (
    .entries     (entries),
    .src         (id_rt),
    .used        (id_rt_used),
    .sel         (rt_sel),
    .is_load_hit (rt_load_hit)
  );

  // A load is only a hazard while it sits in a stage before its data is forwardable.
  assign rs_hazard = rs_load_hit && (rs_sel < SEL_W'(LOAD_READY));
  assign rt_hazard = rt_load_hit && (rt_sel < SEL_W'(LOAD_READY));

  assign stall      = (id_valid && !flush && (rs_hazard || rt_hazard)) || ext_hold;
  assign fwd_rs_sel = id_valid ? rs_sel : SEL_W'(FWD_RF);
  assign fwd_rt_sel = id_valid ? rt_sel : SEL_W'(FWD_RF);

  always_comb begin
    issue.valid   = id_valid && !flush && !stall && id_reg_write && (id_rd != '0);
    issue.rd      = MAX_ADDR_W'(id_rd);
    issue.is_load = id_mem_read;
  end

  always_comb begin
    pending = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      for (int k = 1; k <= DEPTH; k++) begin
        if (entries[k].valid && (entries[k].rd == MAX_ADDR_W'(r))) begin
          pending[r] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the entry array is only DEPTH words of flops, so it is cleared by reset like any
    // other state; the valid bits alone would suffice but clearing all keeps pending clean.
    if (!reset) begin
      entries      <= '0;
      stall_cycles <= '0;
    end else begin
      // NOTE: non-blocking assignments let every entry sample its older neighbour's
      // pre-edge value, so the loop order does not matter.
      if (!ext_hold) begin
        for (int k = DEPTH; k >= 2; k--) begin
          entries[k] <= entries[k-1];
        end
        entries[1] <= issue;
      end
      if (stall && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: ALU chains, load-use, r0, priority, flush/hold,
// asynchronous reset and counter saturation, each with hand-computed expectations.
module tb_hazard_scoreboard;

  localparam int TB_CNT_W = 4;

  logic                clk;
  logic                reset;
  logic                id_valid;
  logic [4:0]          id_rs;
  logic [4:0]          id_rt;
  logic                id_rs_used;
  logic                id_rt_used;
  logic [4:0]          id_rd;
  logic                id_reg_write;
  logic                id_mem_read;
  logic                flush;
  logic                ext_hold;
  logic                stall;
  logic [1:0]          fwd_rs_sel;
  logic [1:0]          fwd_rt_sel;
  logic [31:0]         pending;
  logic [TB_CNT_W-1:0] stall_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  hazard_scoreboard #(
    .NUM_REGS   (32),
    .ADDR_W     (5),
    .DEPTH      (3),
    .LOAD_READY (2),
    .CNT_W      (TB_CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rs_used   (id_rs_used),
    .id_rt_used   (id_rt_used),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .ext_hold     (ext_hold),
    .stall        (stall),
    .fwd_rs_sel   (fwd_rs_sel),
    .fwd_rt_sel   (fwd_rt_sel),
    .pending      (pending),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present an ID instruction; called just after a falling edge, then lets logic settle.
  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic rsu, input logic rtu, input logic [4:0] rd,
                        input logic rw, input logic mr);
    id_valid = v; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr;
    #1;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic next();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    idle();
    repeat (3) next();
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; ext_hold = 1'b0;
    set_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %0b want 0", stall); end
    n_cmp++; if (fwd_rs_sel !== 2'd0) begin n_bad++; $display("FAIL rst_fwd_rs: got %0d want 0", fwd_rs_sel); end
    n_cmp++; if (pending !== 32'h0) begin n_bad++; $display("FAIL rst_pending: got %h want 0", pending); end
    n_cmp++; if (stall_cycles !== 4'd0) begin n_bad++; $display("FAIL rst_cnt: got %0d want 0", stall_cycles); end
    ext_hold = 1'b1; #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL rst_stall_hold: got %0b want 1", stall); end
    ext_hold = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle();
  endtask

  task automatic test_alu_chain();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);   // add r3,r1,r2
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL alu_a_stall: got %0b want 0", stall); end
    next();
    set_id(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);   // sub r4,r3,r5
    n_cmp++; if (fwd_rs_sel !== 2'd1) begin n_bad++; $display("FAIL alu_b_rs: got %0d want 1", fwd_rs_sel); end
    n_cmp++; if (fwd_rt_sel !== 2'd0) begin n_bad++; $display("FAIL alu_b_rt: got %0d want 0", fwd_rt_sel); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL alu_b_stall: got %0b want 0", stall); end
    n_cmp++; if (pending !== 32'h8) begin n_bad++; $display("FAIL alu_b_pending: got %h want 8", pending); end
    next();
    set_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);   // or r6,r3,r0
    n_cmp++; if (fwd_rs_sel !== 2'd2) begin n_bad++; $display("FAIL alu_c_rs: got %0d want 2", fwd_rs_sel); end
    n_cmp++; if (fwd_rt_sel !== 2'd0) begin n_bad++; $display("FAIL alu_c_rt: got %0d want 0", fwd_rt_sel); end
    n_cmp++; if (pending !== 32'h18) begin n_bad++; $display("FAIL alu_c_pending: got %h want 18", pending); end
    next();
    set_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0);  // and r15,r3,r4 : r3 in WB
    n_cmp++; if (fwd_rs_sel !== 2'd3) begin n_bad++; $display("FAIL alu_wb_rs: got %0d want 3", fwd_rs_sel); end
    n_cmp++; if (fwd_rt_sel !== 2'd2) begin n_bad++; $display("FAIL alu_wb_rt: got %0d want 2", fwd_rt_sel); end
    next();
    drain();
    n_cmp++; if (pending !== 32'h0) begin n_bad++; $display("FAIL alu_drain_pending: got %h want 0", pending); end
  endtask

  task automatic test_load_use();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);   // lw r8,0(r1)
    next();
    set_id(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);   // add r9,r8,r8
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall: got %0b want 1", stall); end
    n_cmp++; if (pending !== 32'h100) begin n_bad++; $display("FAIL lu_pending: got %h want 100", pending); end
    next();
    set_id(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lu_release: got %0b want 0", stall); end
    n_cmp++; if (fwd_rs_sel !== 2'd2) begin n_bad++; $display("FAIL lu_rs: got %0d want 2", fwd_rs_sel); end
    n_cmp++; if (fwd_rt_sel !== 2'd2) begin n_bad++; $display("FAIL lu_rt: got %0d want 2", fwd_rt_sel); end
    n_cmp++; if (stall_cycles !== 4'd1) begin n_bad++; $display("FAIL lu_cnt: got %0d want 1", stall_cycles); end
    next();
    drain();
  endtask

  task automatic test_reg_zero();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);   // add r0,r1,r2
    next();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);   // add r5,r0,r0
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL r0_stall: got %0b want 0", stall); end
    n_cmp++; if (fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin n_bad++; $display("FAIL r0_sel: got %0d/%0d want 0/0", fwd_rs_sel, fwd_rt_sel); end
    n_cmp++; if (pending !== 32'h0) begin n_bad++; $display("FAIL r0_pending: got %h want 0", pending); end
    next();
    n_cmp++; if (pending !== 32'h20) begin n_bad++; $display("FAIL r0_issue_pending: got %h want 20", pending); end
    drain();
  endtask

  task automatic test_youngest_wins();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);   // add r7,r1,r2
    next();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1);   // lw r7,0(r1)
    next();
    set_id(1'b1, 5'd7, 5'd1, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);  // add r10,r7,r1
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL yw_stall: got %0b want 1", stall); end
    n_cmp++; if (fwd_rs_sel !== 2'd1) begin n_bad++; $display("FAIL yw_rs: got %0d want 1", fwd_rs_sel); end
    next();
    set_id(1'b1, 5'd7, 5'd1, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL yw_release: got %0b want 0", stall); end
    n_cmp++; if (fwd_rs_sel !== 2'd2) begin n_bad++; $display("FAIL yw_rs_after: got %0d want 2", fwd_rs_sel); end
    n_cmp++; if (stall_cycles !== 4'd2) begin n_bad++; $display("FAIL yw_cnt: got %0d want 2", stall_cycles); end
    next();
    drain();
  endtask

  task automatic test_flush_hold();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b1);  // lw r11,0(r1)
    next();
    flush = 1'b1;
    set_id(1'b1, 5'd11, 5'd0, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0); // add r12,r11,r0 flushed
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL fl_stall: got %0b want 0", stall); end
    next();
    flush = 1'b0;
    idle();
    n_cmp++; if (pending !== 32'h800) begin n_bad++; $display("FAIL fl_pending: got %h want 800", pending); end
    ext_hold = 1'b1;
    flush = 1'b1;
    set_id(1'b1, 5'd11, 5'd0, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0);
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL hold_stall: got %0b want 1", stall); end
    repeat (3) next();
    n_cmp++; if (pending !== 32'h800) begin n_bad++; $display("FAIL hold_pending: got %h want 800", pending); end
    n_cmp++; if (stall_cycles !== 4'd5) begin n_bad++; $display("FAIL hold_cnt: got %0d want 5", stall_cycles); end
    ext_hold = 1'b0;
    flush = 1'b0;
    set_id(1'b1, 5'd11, 5'd0, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0); // add r14,r11,r0
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL hold_release: got %0b want 0", stall); end
    n_cmp++; if (fwd_rs_sel !== 2'd2) begin n_bad++; $display("FAIL hold_rs: got %0d want 2", fwd_rs_sel); end
    next();
    idle();
    n_cmp++; if (pending !== 32'h4800) begin n_bad++; $display("FAIL hold_after_pending: got %h want 4800", pending); end
    drain();
  endtask

  task automatic test_async_reset();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd16, 1'b1, 1'b1);  // lw r16,0(r1)
    next();
    set_id(1'b1, 5'd16, 5'd0, 1'b1, 1'b1, 5'd17, 1'b1, 1'b0); // add r17,r16,r0
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL ar_pre_stall: got %0b want 1", stall); end
    n_cmp++; if (stall_cycles !== 4'd5) begin n_bad++; $display("FAIL ar_pre_cnt: got %0d want 5", stall_cycles); end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (pending !== 32'h0) begin n_bad++; $display("FAIL ar_pending: got %h want 0", pending); end
    n_cmp++; if (fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin n_bad++; $display("FAIL ar_sel: got %0d/%0d want 0/0", fwd_rs_sel, fwd_rt_sel); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL ar_stall: got %0b want 0", stall); end
    n_cmp++; if (stall_cycles !== 4'd0) begin n_bad++; $display("FAIL ar_cnt: got %0d want 0", stall_cycles); end
    @(negedge clk);
    reset = 1'b1;
    idle();
  endtask

  task automatic test_saturation();
    ext_hold = 1'b1;
    idle();
    repeat (20) next();
    n_cmp++; if (stall_cycles !== 4'd15) begin n_bad++; $display("FAIL sat_cnt: got %0d want 15", stall_cycles); end
    ext_hold = 1'b0;
    idle();
    next();
    n_cmp++; if (stall_cycles !== 4'd15) begin n_bad++; $display("FAIL sat_hold_cnt: got %0d want 15", stall_cycles); end
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_load_use();
    test_reg_zero();
    test_youngest_wins();
    test_flush_hold();
    test_async_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
